// File: rtl/bitmode_addr_gen.sv
// rtl/bitmode_addr_gen.sv - bitmap-mode X/Y pixel address generator with post-access auto-step
// Optional: BITMODE_READBACK_EN returns X/Y on CPU reads of BMBASE+0/+1.
module bitmode_addr_gen #(
    parameter logic [15:0] BMBASE   = 16'h0000,
    parameter bit          NIB_SWAP = 1'b0
) (
    input  logic        CLK10,
    input  logic        RESETn,
    input  logic        BUSEN,
    input  logic [15:0] BA,
    input  logic [7:0]  BD,
    input  logic        WRITEn,
    input  logic        XINCn,
    input  logic        YINCn,
    input  logic        AXn,
    input  logic        AYn,
    input  logic [7:0]  VRD,
    output logic        BITMDn,
    output logic        PIXB,
    output logic [14:0] VA,
    output logic [7:0]  BDO,
    output logic        BDOE
);

    localparam logic [15:0] X_ADDR = BMBASE;
    localparam logic [15:0] Y_ADDR = BMBASE + 16'd1;
    localparam logic [15:0] D_ADDR = BMBASE + 16'd2;

    typedef enum logic {IDLE, STEP} state_t;

    state_t      state, next_state;
    logic [7:0]  x_reg, y_reg;
    logic        busen_q;
    logic [15:0] ba_q;
    logic        bus_acc, wr_x, wr_y, bm_acc, step_en;
    logic [3:0]  nib;

    // A strobe held across cycles on the same address is one access; a new address re-arms it.
    assign bus_acc = BUSEN && (!busen_q || (BA != ba_q));
    assign BITMDn  = (BA != D_ADDR);
    assign wr_x    = bus_acc && !WRITEn && (BA == X_ADDR);
    assign wr_y    = bus_acc && !WRITEn && (BA == Y_ADDR);
    assign bm_acc  = bus_acc && !BITMDn;

    always_ff @(posedge CLK10 or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A bitmode access seen during STEP re-enters STEP so its step is not lost.
    always_comb begin
        next_state = IDLE;
        if (bm_acc) begin
            next_state = STEP;
        end
    end

    always_comb begin
        step_en = (state == STEP);
    end

    always_ff @(posedge CLK10 or negedge RESETn) begin
        if (!RESETn) begin
            x_reg   <= 8'h00;
            y_reg   <= 8'h00;
            busen_q <= 1'b0;
            ba_q    <= 16'h0000;
        end else begin
            busen_q <= BUSEN;
            ba_q    <= BA;
            if (wr_x) begin
                x_reg <= BD;
            end else if (step_en && !XINCn) begin
                x_reg <= x_reg + (AXn ? 8'hFF : 8'h01);
            end
            if (wr_y) begin
                y_reg <= BD;
            end else if (step_en && !YINCn) begin
                y_reg <= y_reg + (AYn ? 8'hFF : 8'h01);
            end
        end
    end

    assign PIXB = x_reg[0] ^ NIB_SWAP;
    assign VA   = BITMDn ? BA[14:0] : {y_reg, x_reg[7:1]};
    assign nib  = x_reg[0] ? VRD[7:4] : VRD[3:0];

    always_comb begin
        BDOE = 1'b0;
        BDO  = 8'h00;
        if (!BITMDn && WRITEn) begin
            BDOE = 1'b1;
            BDO  = {nib, nib};
        end
`ifdef BITMODE_READBACK_EN
        else if (WRITEn && (BA == X_ADDR)) begin
            BDOE = 1'b1;
            BDO  = x_reg;
        end else if (WRITEn && (BA == Y_ADDR)) begin
            BDOE = 1'b1;
            BDO  = y_reg;
        end
`endif
    end

endmodule

// File: tb/tb_bitmode_addr_gen.sv
// tb/tb_bitmode_addr_gen.sv - scoreboard bench for bitmode_addr_gen
module tb_bitmode_addr_gen;

    localparam logic [15:0] BMBASE = 16'h4000;
    localparam logic [15:0] X_ADDR = BMBASE;
    localparam logic [15:0] Y_ADDR = BMBASE + 16'd1;
    localparam logic [15:0] D_ADDR = BMBASE + 16'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busen = 1'b0;
    logic [15:0] ba = 16'h1234;
    logic [7:0]  bd = 8'h00;
    logic        writen = 1'b1;
    logic        xincn = 1'b1, yincn = 1'b1, axn = 1'b0, ayn = 1'b0;
    logic [7:0]  vrd = 8'h00;
    logic        bitmdn, pixb, bdoe;
    logic [14:0] va;
    logic [7:0]  bdo;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] obs[$];
    int          n_pass = 0;
    int          n_total = 0;

    bitmode_addr_gen #(.BMBASE(BMBASE), .NIB_SWAP(1'b0)) dut (
        .CLK10(clk), .RESETn(rst_n), .BUSEN(busen), .BA(ba), .BD(bd), .WRITEn(writen),
        .XINCn(xincn), .YINCn(yincn), .AXn(axn), .AYn(ayn), .VRD(vrd),
        .BITMDn(bitmdn), .PIXB(pixb), .VA(va), .BDO(bdo), .BDOE(bdoe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Caller is at a negedge; returns at a negedge after `hold` strobe cycles.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input bit wr, input int hold,
                       output logic [15:0] rd_s, output logic [15:0] va_s);
        ba = a; bd = d; writen = ~wr; busen = 1'b1;
        #1;
        rd_s = {7'b0, bdoe, bdo};
        va_s = {1'b0, va};
        repeat (hold) @(negedge clk);
        busen = 1'b0;
    endtask

    // Observes {Y,X} through the bitmode address view without generating an access.
    task automatic peek(output logic [15:0] v);
        ba = D_ADDR; busen = 1'b0;
        #1;
        v = {va[14:7], va[6:0], pixb};
    endtask

    task automatic load_xy(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] r, v;
        @(negedge clk);
        bus(X_ADDR, x, 1'b1, 1, r, v);
        bus(Y_ADDR, y, 1'b1, 1, r, v);
    endtask

    task automatic drain();
        while (sb.size() > 0 && obs.size() > 0) begin
            exp_t        e;
            logic [15:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val);
            else n_pass++;
        end
        if (sb.size() != 0 || obs.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_balance: got %0d obs want %0d", obs.size(), sb.size());
            sb.delete();
            obs.delete();
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        sb.push_back('{"reset_xy", 16'h0000});
        sb.push_back('{"reset_bdoe", 16'h0000});
        peek(v); obs.push_back(v);
        ba = 16'h1234; #1; obs.push_back({7'b0, bdoe, bdo});
        drain();
    endtask

    task automatic test_load_read();
        logic [15:0] r, v;
        load_xy(8'h12, 8'h34);
        xincn = 1'b1; yincn = 1'b1; vrd = 8'hA5;
        sb.push_back('{"read_va", 16'h1A09});
        sb.push_back('{"read_pixb", 16'h0000});
        sb.push_back('{"read_bdo", 16'h0155});
        sb.push_back('{"read_noinc", 16'h3412});
        bus(D_ADDR, 8'h00, 1'b0, 1, r, v);
        obs.push_back(v); obs.push_back({15'b0, pixb}); obs.push_back(r);
        @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_x_wrap();
        logic [15:0] r, v;
        load_xy(8'hFF, 8'h77);
        xincn = 1'b0; axn = 1'b0; yincn = 1'b1;
        sb.push_back('{"wrap_stable", 16'h77FF});
        sb.push_back('{"wrap_step", 16'h7700});
        bus(D_ADDR, 8'h3C, 1'b1, 1, r, v);
        peek(v); obs.push_back(v);
        @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_dec_both();
        logic [15:0] r, v;
        load_xy(8'h00, 8'h00);
        xincn = 1'b0; axn = 1'b1; yincn = 1'b0; ayn = 1'b1; vrd = 8'hA5;
        sb.push_back('{"dec_bdo", 16'h0155});
        sb.push_back('{"dec_step", 16'hFFFF});
        bus(D_ADDR, 8'h00, 1'b0, 1, r, v);
        obs.push_back(r);
        @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_held_busen();
        logic [15:0] r, v;
        load_xy(8'h10, 8'h00);
        xincn = 1'b0; axn = 1'b0; yincn = 1'b1;
        sb.push_back('{"held_once", 16'h0011});
        bus(D_ADDR, 8'h00, 1'b0, 3, r, v);
        repeat (2) @(negedge clk);
        peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] r, v;
        load_xy(8'h20, 8'h30);
        xincn = 1'b0; axn = 1'b0; yincn = 1'b0; ayn = 1'b0;
        sb.push_back('{"b2b_loadwins", 16'h3140});
        sb.push_back('{"b2b_settled", 16'h3140});
        bus(D_ADDR, 8'h00, 1'b1, 1, r, v);
        bus(X_ADDR, 8'h40, 1'b1, 1, r, v);
        peek(v); obs.push_back(v);
        @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_no_inc();
        logic [15:0] r, v;
        load_xy(8'hAB, 8'hCD);
        xincn = 1'b1; yincn = 1'b1; vrd = 8'h3C;
        sb.push_back('{"noinc_bdo_hi", 16'h0133});
        sb.push_back('{"noinc_xy", 16'hCDAB});
        bus(D_ADDR, 8'h00, 1'b0, 1, r, v);
        obs.push_back(r);
        repeat (2) @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_outside();
        logic [15:0] r, v;
        xincn = 1'b0; yincn = 1'b0;
        sb.push_back('{"out_va", 16'h1234});
        sb.push_back('{"out_bdoe", 16'h0000});
        sb.push_back('{"out_xy", 16'hCDAB});
        @(negedge clk);
        bus(16'h1234, 8'h99, 1'b1, 1, r, v);
        bus(BMBASE + 16'd3, 8'h11, 1'b1, 1, r, v);
        bus(16'h1234, 8'h00, 1'b0, 1, r, v);
        obs.push_back(v); obs.push_back(r);
        repeat (2) @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    task automatic test_readback();
        logic [15:0] r, v;
        load_xy(8'h5A, 8'hC3);
`ifdef BITMODE_READBACK_EN
        sb.push_back('{"rb_x", 16'h015A});
        sb.push_back('{"rb_y", 16'h01C3});
`else
        sb.push_back('{"rb_x_off", 16'h0000});
        sb.push_back('{"rb_y_off", 16'h0000});
`endif
        bus(X_ADDR, 8'h00, 1'b0, 1, r, v); obs.push_back(r);
        bus(Y_ADDR, 8'h00, 1'b0, 1, r, v); obs.push_back(r);
        drain();
    endtask

    task automatic test_reset_mid_step();
        logic [15:0] r, v;
        load_xy(8'h81, 8'h42);
        xincn = 1'b0; axn = 1'b0; yincn = 1'b0;
        sb.push_back('{"rst_async_xy", 16'h0000});
        sb.push_back('{"rst_async_bdoe", 16'h0000});
        sb.push_back('{"rst_after_xy", 16'h0000});
        bus(D_ADDR, 8'h00, 1'b1, 1, r, v);
        rst_n = 1'b0;
        peek(v); obs.push_back(v); obs.push_back({7'b0, bdoe, bdo});
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk); peek(v); obs.push_back(v);
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_load_read();
        test_x_wrap();
        test_dec_both();
        test_held_busen();
        test_back_to_back();
        test_no_inc();
        test_outside();
        test_readback();
        test_reset_mid_step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
